// File: rtl/bitscan16_pkg.sv
// Shared definitions for the bit-index extractor: scan states, direction codes, default sizes.
package bitscan16_pkg;

    localparam int W_DEF  = 16;
    localparam int IW_DEF = 4;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bitscan16_penc16.sv
// Combinational priority encoder: index of the lowest set bit, or of the highest when dir selects MSB.
module penc16
    import bitscan16_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic [W-1:0]  w,
    input  logic          dir,
    output logic [IW-1:0] c,
    output logic          nz
);

    logic [W-1:0]  w_rev;
    logic [W-1:0]  w_sel;
    logic [IW-1:0] idx;

    // MSB-first reuses the LSB encoder: reverse the word, then invert the index back.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rev
            assign w_rev[gi] = w[W-1-gi];
        end
    endgenerate

    assign w_sel = (dir == DIR_MSB) ? w_rev : w;

    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign c  = (dir == DIR_MSB) ? ~idx : idx;
    assign nz = |w;

endmodule

// File: rtl/bitscan16.sv
// Sequential bit-index extractor: loads a word and hands out the index of each set bit per handshake.
module bitscan16
    import bitscan16_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [W-1:0]  a,
    input  logic          dir,
    input  logic          abt,
    input  logic          rdy,
    output logic          v,
    output logic [IW-1:0] c,
    output logic          last,
    output logic          z,
    output logic [IW:0]   cnt,
    output logic          busy
);

    state_t        state_reg;
    logic [W-1:0]  w_reg;
    logic          dir_reg;
    logic [IW:0]   cnt_reg;
    logic          z_reg;

    logic [IW-1:0] c_idx;
    logic          w_nz;
    logic [W-1:0]  bit_sel;
    logic [W-1:0]  w_clr;
    logic          last_hit;
    logic          scan;

    penc16 #(
        .W  (W),
        .IW (IW)
    ) u_penc (
        .w   (w_reg),
        .dir (dir_reg),
        .c   (c_idx),
        .nz  (w_nz)
    );

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_sel
            assign bit_sel[gi] = (c_idx == IW'(gi));
        end
    endgenerate

    assign w_clr    = w_reg & ~bit_sel;
    assign last_hit = ~|w_clr;
    assign scan     = (state_reg == ST_SCAN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            w_reg     <= '0;
            dir_reg   <= DIR_LSB;
            cnt_reg   <= '0;
            z_reg     <= 1'b0;
        end else begin
            z_reg <= 1'b0;
            if (abt) begin
                // Abort wins over load and accept; the count keeps what was already accepted.
                state_reg <= ST_IDLE;
                w_reg     <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (ld) begin
                            w_reg   <= a;
                            dir_reg <= dir;
                            cnt_reg <= '0;
                            if (a == '0) begin
                                z_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_SCAN;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (rdy) begin
                            w_reg   <= w_clr;
                            cnt_reg <= cnt_reg + (IW+1)'(1);
                            if (last_hit || !w_nz) begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign v    = scan;
    assign busy = scan;
    assign c    = c_idx;
    assign last = scan & last_hit;
    assign z    = z_reg;
    assign cnt  = cnt_reg;

endmodule

// File: tb/tb_bitscan16.sv
// Randomized self-checking bench for bitscan16 against a bit-set model, plus directed literal cases.
module tb_bitscan16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld  = 1'b0;
    logic [15:0] a   = 16'h0;
    logic        dir = 1'b0;
    logic        abt = 1'b0;
    logic        rdy = 1'b0;
    logic        v;
    logic [3:0]  c;
    logic        last;
    logic        z;
    logic [4:0]  cnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Model state: remaining bits, captured order, accepted count, zero pulse, busy flag
    logic [15:0] m_w;
    logic        m_dir;
    int          m_cnt;
    logic        m_z;
    logic        m_busy;

    bitscan16 dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .dir  (dir),
        .abt  (abt),
        .rdy  (rdy),
        .v    (v),
        .c    (c),
        .last (last),
        .z    (z),
        .cnt  (cnt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [15:0] x, input logic msb);
        if (msb) begin
            for (int i = 15; i >= 0; i--) if (x[i]) return i;
        end else begin
            for (int i = 0; i < 16; i++) if (x[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] nw;
        int e;
        if (rst) begin
            m_w <= 16'h0; m_dir <= 1'b0; m_cnt <= 0; m_z <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_z <= 1'b0;
            if (abt) begin
                m_busy <= 1'b0;
                m_w    <= 16'h0;
            end else if (!m_busy) begin
                if (ld) begin
                    m_w   <= a;
                    m_dir <= dir;
                    m_cnt <= 0;
                    if (a == 16'h0) m_z <= 1'b1;
                    else            m_busy <= 1'b1;
                end
            end else if (rdy) begin
                e  = first_set(m_w, m_dir);
                nw = m_w;
                nw[e] = 1'b0;
                m_w   <= nw;
                m_cnt <= m_cnt + 1;
                if (nw == 16'h0) m_busy <= 1'b0;
                $display("accept idx=%0d cnt=%0d last=%0d", e, m_cnt + 1, (nw == 16'h0));
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("v", {31'b0, v}, {31'b0, m_busy});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("z", {31'b0, z}, {31'b0, m_z});
            check("cnt", {27'b0, cnt}, m_cnt);
            check("z_v_excl", {31'b0, z & v}, 32'd0);
            if (m_busy) begin
                check("c", {28'b0, c}, first_set(m_w, m_dir));
                check("last", {31'b0, last}, {31'b0, ($countones(m_w) == 1)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp2 [4];
        logic [3:0] exp3 [4];
        int k;
        bit r;
        exp2[0] = 4'd0;  exp2[1] = 4'd5;  exp2[2] = 4'd10; exp2[3] = 4'd15;
        exp3[0] = 4'd15; exp3[1] = 4'd10; exp3[2] = 4'd5;  exp3[3] = 4'd0;

        #2 rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checking = 1'b1;
        check("rst_v", {31'b0, v}, 0);
        check("rst_c", {28'b0, c}, 0);
        check("rst_last", {31'b0, last}, 0);
        check("rst_z", {31'b0, z}, 0);
        check("rst_cnt", {27'b0, cnt}, 0);
        check("rst_busy", {31'b0, busy}, 0);

        // 1: zero word
        ld = 1'b1; a = 16'h0000; dir = 1'b0;
        step();
        ld = 1'b0;
        check("t1_z", {31'b0, z}, 1);
        check("t1_v", {31'b0, v}, 0);
        check("t1_busy", {31'b0, busy}, 0);
        check("t1_cnt", {27'b0, cnt}, 0);
        step();
        check("t1_z_drop", {31'b0, z}, 0);

        // 2: LSB-first, rdy high
        ld = 1'b1; a = 16'h8421; dir = 1'b0; rdy = 1'b1;
        step();
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_v", {31'b0, v}, 1);
            check("t2_c", {28'b0, c}, {28'b0, exp2[i]});
            check("t2_last", {31'b0, last}, (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("t2_v_end", {31'b0, v}, 0);
        check("t2_cnt", {27'b0, cnt}, 4);

        // 3: MSB-first, rdy toggling
        ld = 1'b1; a = 16'h8421; dir = 1'b1;
        step();
        ld = 1'b0;
        k = 0; r = 1'b1;
        for (int g = 0; g < 20 && v; g++) begin
            check("t3_c", {28'b0, c}, {28'b0, exp3[k]});
            check("t3_last", {31'b0, last}, (k == 3) ? 32'd1 : 32'd0);
            rdy = r;
            if (r) k++;
            r = ~r;
            step();
        end
        check("t3_done", {31'b0, v}, 0);
        check("t3_cnt", {27'b0, cnt}, 4);

        // 4: all ones
        ld = 1'b1; a = 16'hFFFF; dir = 1'b0; rdy = 1'b1;
        step();
        ld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t4_busy", {31'b0, busy}, 1);
            check("t4_c", {28'b0, c}, i);
            step();
        end
        check("t4_busy_end", {31'b0, busy}, 0);
        check("t4_cnt", {27'b0, cnt}, 16);

        // 5: abort with first accept, then reload
        ld = 1'b1; a = 16'h00F0; dir = 1'b0; rdy = 1'b1;
        step();
        ld = 1'b0;
        check("t5_c", {28'b0, c}, 4);
        abt = 1'b1;
        step();
        abt = 1'b0;
        check("t5_v", {31'b0, v}, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_cnt", {27'b0, cnt}, 0);
        ld = 1'b1; a = 16'h0002;
        step();
        ld = 1'b0;
        check("t5_c2", {28'b0, c}, 1);
        check("t5_last2", {31'b0, last}, 1);
        step();
        check("t5_cnt2", {27'b0, cnt}, 1);
        ld = 1'b1; a = 16'h0000; abt = 1'b1;
        step();
        ld = 1'b0; abt = 1'b0;
        check("t5_abt_ld_z", {31'b0, z}, 0);

        // 6: ld ignored while scanning, then async reset mid-scan
        ld = 1'b1; a = 16'h8421; dir = 1'b0; rdy = 1'b0;
        step();
        a = 16'hFFFF;
        step(); step();
        ld = 1'b0;
        check("t6_c", {28'b0, c}, 0);
        check("t6_cnt", {27'b0, cnt}, 0);
        check("t6_last", {31'b0, last}, 0);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("t6_c2", {28'b0, c}, 5);
        check("t6_cnt2", {27'b0, cnt}, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_v", {31'b0, v}, 0);
        check("t6_rst_busy", {31'b0, busy}, 0);
        check("t6_rst_c", {28'b0, c}, 0);
        check("t6_rst_cnt", {27'b0, cnt}, 0);
        check("t6_rst_last", {31'b0, last}, 0);
        step();
        rst = 1'b0;
        step();

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'(1) << $urandom_range(0, 15);
                default: a = 16'($urandom);
            endcase
            ld  = ($urandom_range(0, 3) == 0);
            dir = 1'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            abt = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        ld = 1'b0; abt = 1'b0; rst = 1'b0; rdy = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
